neuron_sequencer: RTL

Control-side initiator for the `Neuron` datapath. It walks one layer of a fully connected network: for each neuron it clears the accumulator, streams input and weight addresses to synchronous memories, and accumulates each data/weight product. It then latches the ReLU/saturated result and issues a write into the layer-result buffer. One sequencer drives one neuron instance; the top level chains sequencers per layer using `start` and `done`.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/neuron_sequencer_if.sv | 34 +++
 rtl/mod_counter.sv | 28 ++
 rtl/neuron_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and default layer geometry for the fully connected layer sequencers.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        MAC   = 3'd2,
        RELU  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } seqState_t;

    localparam int DEF_N_INPUTS = 62;
    localparam int DEF_N_HIDDEN = 30;
    localparam int DEF_N_OUTPUT = 10;

    localparam int DEF_DATA_AW   = $clog2(DEF_N_INPUTS);
    localparam int DEF_WEIGHT_AW = $clog2(DEF_N_INPUTS * DEF_N_HIDDEN);
    localparam int DEF_NEURON_AW = $clog2(DEF_N_HIDDEN);

endpackage

// File: rtl/neuron_sequencer_if.sv
// Control/address bundle between a layer sequencer and its neuron, memories and result buffer.
interface neuron_sequencer_if
    import nn_pkg::*;
#(
    parameter int DATA_AW   = DEF_DATA_AW,
    parameter int WEIGHT_AW = DEF_WEIGHT_AW,
    parameter int NEURON_AW = DEF_NEURON_AW
);

    logic                 start;
    logic                 ready;
    logic                 done;
    logic [DATA_AW-1:0]   dataAddr;
    logic [WEIGHT_AW-1:0] weightAddr;
    logic [NEURON_AW-1:0] biasAddr;
    logic                 init;
    logic                 enMac;
    logic                 enReLU;
    logic                 resultWe;
    logic [NEURON_AW-1:0] resultAddr;

    modport master (
        input  start,
        output ready, done, dataAddr, weightAddr, biasAddr,
               init, enMac, enReLU, resultWe, resultAddr
    );

    modport slave (
        output start,
        input  ready, done, dataAddr, weightAddr, biasAddr,
               init, enMac, enReLU, resultWe, resultAddr
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo counter with synchronous clear and a terminal-count flag.
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    assign last = (count == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Walks one fully connected layer: per neuron clear, stream N_INPUTS MAC steps, latch ReLU, write result.
module neuron_sequencer
    import nn_pkg::*;
#(
    parameter int N_INPUTS  = DEF_N_INPUTS,
    parameter int N_NEURONS = DEF_N_HIDDEN,
    parameter int DATA_AW   = DEF_DATA_AW,
    parameter int WEIGHT_AW = DEF_WEIGHT_AW,
    parameter int NEURON_AW = DEF_NEURON_AW
) (
    input  logic               clk,
    input  logic               rst,
    neuron_sequencer_if.master bus
);

    localparam logic [WEIGHT_AW-1:0] W_LAST = WEIGHT_AW'(N_INPUTS * N_NEURONS - 1);

    seqState_t            state;
    seqState_t            nextState;
    logic [WEIGHT_AW-1:0] wPtr;
    logic [DATA_AW-1:0]   inIdx;
    logic [NEURON_AW-1:0] neuronIdx;
    logic                 inLast;
    logic                 neuronLast;

    logic                 ready;
    logic                 done;
    logic                 init;
    logic                 enMac;
    logic                 enReLU;
    logic                 resultWe;
    logic [DATA_AW-1:0]   dataAddr;
    logic [WEIGHT_AW-1:0] weightAddr;
    logic [NEURON_AW-1:0] resultAddr;

    mod_counter #(
        .WIDTH    (DATA_AW),
        .TERMINAL (N_INPUTS - 1)
    ) inCounter (
        .clk   (clk),
        .rst   (rst),
        .clear (state == INIT),
        .en    (state == MAC),
        .count (inIdx),
        .last  (inLast)
    );

    // Cleared in DONE as well so biasAddr already reads 0 in the IDLE that follows a pass.
    mod_counter #(
        .WIDTH    (NEURON_AW),
        .TERMINAL (N_NEURONS - 1)
    ) neuronCounter (
        .clk   (clk),
        .rst   (rst),
        .clear ((state == IDLE) || (state == DONE)),
        .en    ((state == WRITE) && !neuronLast),
        .count (neuronIdx),
        .last  (neuronLast)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Running weight pointer; holds at the final address so it never wraps within a pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wPtr <= '0;
        end else begin
            case (state)
                IDLE:    wPtr <= '0;
                INIT:    if (wPtr != W_LAST) wPtr <= wPtr + WEIGHT_AW'(1);
                MAC:     if (!inLast && (wPtr != W_LAST)) wPtr <= wPtr + WEIGHT_AW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState  = state;
        ready      = 1'b0;
        done       = 1'b0;
        init       = 1'b0;
        enMac      = 1'b0;
        enReLU     = 1'b0;
        resultWe   = 1'b0;
        dataAddr   = '0;
        weightAddr = '0;
        resultAddr = '0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) nextState = INIT;
            end
            INIT: begin
                init       = 1'b1;
                weightAddr = wPtr;
                nextState  = MAC;
            end
            MAC: begin
                enMac      = 1'b1;
                dataAddr   = inIdx + DATA_AW'(1);
                weightAddr = wPtr;
                if (inLast) nextState = RELU;
            end
            RELU: begin
                enReLU    = 1'b1;
                nextState = WRITE;
            end
            WRITE: begin
                resultWe   = 1'b1;
                resultAddr = neuronIdx;
                nextState  = neuronLast ? DONE : INIT;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign bus.ready      = ready;
    assign bus.done       = done;
    assign bus.init       = init;
    assign bus.enMac      = enMac;
    assign bus.enReLU     = enReLU;
    assign bus.resultWe   = resultWe;
    assign bus.dataAddr   = dataAddr;
    assign bus.weightAddr = weightAddr;
    assign bus.biasAddr   = neuronIdx;
    assign bus.resultAddr = resultAddr;

endmodule
